rmii_tx_framer: RTL

- Transmit framing stage between the 2 kB transmit buffer RAM (dibit read port) and the RMII output retiming registers.
- On a start command it emits preamble and SFD, streams the CPU-formatted frame dibits from the buffer, then appends the IEEE 802.3 CRC-32 FCS and enforces the inter-frame gap.
- The CPU therefore no longer computes FCS in software.

---
 rtl/rmii_tx_framer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : rmii_tx_framer
// Summary  : RMII transmit framer. Sends preamble/SFD, then the payload read
//            from the dibit buffer, then the CRC-32 FCS and the inter-frame
//            gap. Defining RMII_TX_PAD_EN pads short frames to 60 bytes.
// Revision : 1.0  initial release
// ============================================================================
module rmii_tx_framer #(
  parameter int IFG_DIBITS = 48,
  parameter int LEN_W      = 13
) (
  input  logic             rclk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] raddr,
  input  logic [1:0]       rdata,
  output logic [1:0]       txd,
  output logic             txv,
  output logic             busy,
  output logic [31:0]      crc_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_FCS  = 3'd4,
    S_IFG  = 3'd5
  } state_t;

  localparam logic [31:0]      c_poly     = 32'hEDB8_8320;
  localparam logic [LEN_W-1:0] c_one      = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_pre_last = LEN_W'(31);
  localparam logic [LEN_W-1:0] c_fcs_last = LEN_W'(15);
  localparam logic [LEN_W-1:0] c_ifg_last = LEN_W'(IFG_DIBITS - 1);
`ifdef RMII_TX_PAD_EN
  localparam logic [LEN_W-1:0] c_min_len  = LEN_W'(240);
  localparam logic [LEN_W-1:0] c_pad_last = LEN_W'(239);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_len_m1;
  logic [LEN_W-1:0] r_raddr;
  logic [LEN_W-1:0] w_raddr_nxt;
  logic [31:0]      r_crc;
  logic [31:0]      w_crc_nxt;
  logic [1:0]       w_fcs_dibit;
  logic [1:0]       r_txd;
  logic [1:0]       w_txd;
  logic             r_txv;
  logic             w_txv;
  logic             r_busy;
  logic             w_busy;

  // Reflected CRC-32, two bits per call, bit0 enters first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] v;
    v = c;
    for (int b = 0; b < 2; b++) begin
      if (v[0] ^ d[b]) v = (v >> 1) ^ c_poly;
      else             v = v >> 1;
    end
    return v;
  endfunction

  assign w_len_m1    = r_len - c_one;
  assign w_fcs_dibit = r_crc[{r_cnt[3:0], 1'b0} +: 2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_one;
    w_len_nxt   = r_len;
    w_raddr_nxt = r_raddr;
    w_crc_nxt   = r_crc;
    w_txd       = 2'b00;
    w_txv       = 1'b0;
    w_busy      = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_busy    = 1'b0;
        w_cnt_nxt = '0;
        // The registered busy closes the window on the edge IFG drains.
        if (start && !r_busy) begin
          w_state_nxt = S_PRE;
          w_len_nxt   = len;
          w_raddr_nxt = '0;
        end
      end

      S_PRE: begin
        w_txv = 1'b1;
        if (r_cnt == c_pre_last) begin
          w_txd     = 2'b11;
          w_crc_nxt = '1;
          w_cnt_nxt = '0;
          if (r_len != '0) begin
            w_state_nxt = S_DATA;
          end else begin
`ifdef RMII_TX_PAD_EN
            w_state_nxt = S_PAD;
`else
            w_state_nxt = S_FCS;
`endif
          end
        end else begin
          w_txd = 2'b01;
        end
      end

      S_DATA: begin
        w_txv     = 1'b1;
        w_txd     = rdata;
        w_crc_nxt = crc_dibit(r_crc, rdata);
        if (r_cnt == w_len_m1) begin
`ifdef RMII_TX_PAD_EN
          // Counter keeps running into PAD so it tracks total payload.
          if (r_len < c_min_len) begin
            w_state_nxt = S_PAD;
          end else begin
            w_state_nxt = S_FCS;
            w_cnt_nxt   = '0;
          end
`else
          w_state_nxt = S_FCS;
          w_cnt_nxt   = '0;
`endif
        end
      end

`ifdef RMII_TX_PAD_EN
      S_PAD: begin
        w_txv     = 1'b1;
        w_txd     = 2'b00;
        w_crc_nxt = crc_dibit(r_crc, 2'b00);
        if (r_cnt == c_pad_last) begin
          w_state_nxt = S_FCS;
          w_cnt_nxt   = '0;
        end
      end
`endif

      S_FCS: begin
        w_txv = 1'b1;
        w_txd = ~w_fcs_dibit;
        if (r_cnt == c_fcs_last) begin
          w_state_nxt = S_IFG;
          w_cnt_nxt   = '0;
        end
      end

      S_IFG: begin
        if (r_cnt == c_ifg_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_busy      = 1'b0;
      end
    endcase

    // Address runs one cycle ahead of the dibit it fetches.
    if (w_state_nxt == S_DATA) begin
      w_raddr_nxt = r_raddr + c_one;
    end
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_raddr <= '0;
      r_crc   <= '1;
      r_txd   <= 2'b00;
      r_txv   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_raddr <= w_raddr_nxt;
      r_crc   <= w_crc_nxt;
      r_txd   <= w_txd;
      r_txv   <= w_txv;
      r_busy  <= w_busy;
    end
  end

  assign raddr   = r_raddr;
  assign txd     = r_txd;
  assign txv     = r_txv;
  assign busy    = r_busy;
  assign crc_out = r_crc;

endmodule
`default_nettype wire
